cpu_dbg_dump: RTL and testbench

//  Debug read-out engine for the mini CPU; drives the CPU-state path out of the core.

---
 rtl/cpu_dbg_dump.sv | 196 +++++++++++++++++++
 tb/tb_cpu_dbg_dump.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dbg_dump.sv
// cpu_dbg_dump: debug read-out engine for the mini CPU.
// Counts executed cycles, snapshots CPU state on a trigger and streams the
// snapshot as a fixed 10-byte frame over a valid/ready byte interface.
module cpu_dbg_dump #(
  parameter logic [7:0] HDR_BYTE     = 8'hA5,
  parameter int         CNT_W        = 16,
  parameter bit         AUTO_ON_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             halt,
  input  logic [7:0]       PC,
  input  logic [7:0]       dbg_r0,
  input  logic [7:0]       dbg_r1,
  input  logic [7:0]       dbg_r2,
  input  logic [7:0]       dbg_r3,
  input  logic [2:0]       dbg_state,
  input  logic             dump_req,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       LAST_IDX = 4'd9;

  // XOR checksum over the nine payload bytes of a frame.
  function automatic logic [7:0] frame_xor(
    input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
    input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
    input logic [7:0] b6, input logic [7:0] b7, input logic [7:0] b8
  );
    frame_xor = b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6 ^ b7 ^ b8;
  endfunction

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             halt_q;
  logic [7:0]       snap_pc_q;
  logic [7:0]       snap_r0_q;
  logic [7:0]       snap_r1_q;
  logic [7:0]       snap_r2_q;
  logic [7:0]       snap_r3_q;
  logic [7:0]       snap_stat_q;
  logic [15:0]      snap_cnt_q;
  logic [7:0]       snap_chk_q;
  logic             out_valid_q;
  logic [7:0]       out_data_q;
  logic             out_last_q;
  logic             busy_q;

  logic             halt_rise_s;
  logic             trigger_s;
  logic [15:0]      cnt_ext_s;
  logic [7:0]       stat_live_s;
  logic [7:0]       chk_live_s;
  logic [3:0]       next_idx_s;
  logic [7:0]       next_byte_s;

  // Trigger detection and the live values captured into a snapshot.
  always_comb begin
    halt_rise_s = halt && !halt_q;
    trigger_s   = dump_req || (AUTO_ON_HALT && halt_rise_s);
    cnt_ext_s   = 16'(cnt_q);
    stat_live_s = {halt, en, 3'b000, dbg_state};
    chk_live_s  = frame_xor(HDR_BYTE, PC, dbg_r0, dbg_r1, dbg_r2, dbg_r3,
                            stat_live_s, cnt_ext_s[15:8], cnt_ext_s[7:0]);
  end

  // Saturating executed-cycle counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (en && !halt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Byte that follows the one currently presented, taken from the snapshot only.
  always_comb begin
    next_idx_s  = idx_q + 4'd1;
    next_byte_s = 8'h00;
    case (next_idx_s)
      4'd1:    next_byte_s = snap_pc_q;
      4'd2:    next_byte_s = snap_r0_q;
      4'd3:    next_byte_s = snap_r1_q;
      4'd4:    next_byte_s = snap_r2_q;
      4'd5:    next_byte_s = snap_r3_q;
      4'd6:    next_byte_s = snap_stat_q;
      4'd7:    next_byte_s = snap_cnt_q[15:8];
      4'd8:    next_byte_s = snap_cnt_q[7:0];
      4'd9:    next_byte_s = snap_chk_q;
      default: next_byte_s = 8'h00;
    endcase
  end

  // Cycle counter and halt edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CNT_W{1'b0}};
      halt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      halt_q <= halt;
    end
  end

  // Frame FSM: snapshot on trigger, then stream bytes 0..9 under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      snap_pc_q   <= 8'h00;
      snap_r0_q   <= 8'h00;
      snap_r1_q   <= 8'h00;
      snap_r2_q   <= 8'h00;
      snap_r3_q   <= 8'h00;
      snap_stat_q <= 8'h00;
      snap_cnt_q  <= 16'h0000;
      snap_chk_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trigger_s) begin
            snap_pc_q   <= PC;
            snap_r0_q   <= dbg_r0;
            snap_r1_q   <= dbg_r1;
            snap_r2_q   <= dbg_r2;
            snap_r3_q   <= dbg_r3;
            snap_stat_q <= stat_live_s;
            snap_cnt_q  <= cnt_ext_s;
            snap_chk_q  <= chk_live_s;
            idx_q       <= 4'd0;
            out_data_q  <= HDR_BYTE;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_SEND;
          end else begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        ST_SEND: begin
          // Triggers are ignored here; they are not queued.
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              idx_q       <= 4'd0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              idx_q      <= next_idx_s;
              out_data_q <= next_byte_s;
              out_last_q <= (next_idx_s == LAST_IDX);
            end
          end else begin
            idx_q <= idx_q;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= 4'd0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign cyc_cnt   = cnt_q;

endmodule

// File: tb/tb_cpu_dbg_dump.sv
// Self-checking bench for cpu_dbg_dump: scoreboard of expected frame bytes,
// popped by a monitor on every handshake; scenario tasks check the rest inline.
module tb_cpu_dbg_dump;

  logic        clk = 1'b0;
  logic        rst, en, halt, dump_req, out_ready;
  logic [7:0]  PC, dbg_r0, dbg_r1, dbg_r2, dbg_r3;
  logic [2:0]  dbg_state;
  logic        out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [15:0] cyc_cnt;

  logic        rst_b, en_b, halt_b, dump_req_b, ready_b;
  logic        out_valid_b, out_last_b, busy_b;
  logic [7:0]  out_data_b;
  logic [8:0]  cyc_cnt_b;

  typedef struct packed { logic [7:0] d; logic l; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always #5 clk = ~clk;

  cpu_dbg_dump #(.HDR_BYTE(8'hA5), .CNT_W(16), .AUTO_ON_HALT(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .halt(halt), .PC(PC),
    .dbg_r0(dbg_r0), .dbg_r1(dbg_r1), .dbg_r2(dbg_r2), .dbg_r3(dbg_r3),
    .dbg_state(dbg_state), .dump_req(dump_req),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .cyc_cnt(cyc_cnt)
  );

  cpu_dbg_dump #(.HDR_BYTE(8'hA5), .CNT_W(9), .AUTO_ON_HALT(1'b1)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .halt(halt_b), .PC(PC),
    .dbg_r0(dbg_r0), .dbg_r1(dbg_r1), .dbg_r2(dbg_r2), .dbg_r3(dbg_r3),
    .dbg_state(dbg_state), .dump_req(dump_req_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b),
    .out_ready(ready_b), .busy(busy_b), .cyc_cnt(cyc_cnt_b)
  );

  // Monitor: pops the scoreboard on each handshake and checks stalled bytes hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra: got d=%h l=%b want no byte", out_data, out_last);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            n_err++;
            $display("FAIL sb_byte: got d=%h l=%b want d=%h l=%b", out_data, out_last, e.d, e.l);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] pc, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3, input logic [2:0] st,
                            input logic h, input logic e, input logic [15:0] c);
    logic [7:0] b [10];
    b[0] = 8'hA5; b[1] = pc; b[2] = r0; b[3] = r1; b[4] = r2; b[5] = r3;
    b[6] = {h, e, 3'b000, st}; b[7] = c[15:8]; b[8] = c[7:0];
    b[9] = 8'h00;
    for (int i = 0; i < 9; i++) b[9] = b[9] ^ b[i];
    for (int i = 0; i < 10; i++) sb.push_back('{d: b[i], l: (i == 9)});
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    n_cmp++;
    if (busy || sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: got busy=%b pending=%0d want busy=0 pending=0", name, busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (cyc_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cyc_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_counter();
    en = 1'b1;
    repeat (37) tick();
    n_cmp++; if (cyc_cnt !== 16'd37) begin n_err++; $display("FAIL cnt_run: got %0d want 37", cyc_cnt); end
    PC = 8'h21; dbg_r0 = 8'h31; dbg_r1 = 8'h41; dbg_r2 = 8'h51; dbg_r3 = 8'h61; dbg_state = 3'd2;
    push_frame(8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 3'd2, 1'b1, 1'b1, 16'd37);
    halt = 1'b1;
    repeat (6) tick();
    n_cmp++; if (cyc_cnt !== 16'd37) begin n_err++; $display("FAIL cnt_halt: got %0d want 37", cyc_cnt); end
    wait_idle("counter");
    n_cmp++; if (cyc_cnt !== 16'd37) begin n_err++; $display("FAIL cnt_hold: got %0d want 37", cyc_cnt); end
  endtask

  task automatic test_auto_dump();
    rst = 1'b1; halt = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    repeat (20) tick();
    PC = 8'h03; dbg_r0 = 8'h00; dbg_r1 = 8'h01; dbg_r2 = 8'h05; dbg_r3 = 8'h00; dbg_state = 3'd3;
    out_ready = 1'b1;
    sb.push_back('{d: 8'hA5, l: 1'b0}); sb.push_back('{d: 8'h03, l: 1'b0});
    sb.push_back('{d: 8'h00, l: 1'b0}); sb.push_back('{d: 8'h01, l: 1'b0});
    sb.push_back('{d: 8'h05, l: 1'b0}); sb.push_back('{d: 8'h00, l: 1'b0});
    sb.push_back('{d: 8'hC3, l: 1'b0}); sb.push_back('{d: 8'h00, l: 1'b0});
    sb.push_back('{d: 8'h14, l: 1'b0}); sb.push_back('{d: 8'h75, l: 1'b1});
    halt = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL auto_pre: got %b want 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL auto_latency: got v=%b b=%b want 1 1", out_valid, busy); end
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL auto_hdr: got %h want a5", out_data); end
    repeat (9) tick();
    n_cmp++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin n_err++; $display("FAIL auto_last: got v=%b l=%b want 1 1", out_valid, out_last); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL auto_end: got v=%b b=%b want 0 0", out_valid, busy); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL auto_count: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int h0;
    int k;
    pat = 4'b1001;
    PC = 8'h5A; dbg_r0 = 8'h11; dbg_r1 = 8'h22; dbg_r2 = 8'h33; dbg_r3 = 8'h44; dbg_state = 3'd5;
    push_frame(8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 3'd5, 1'b1, 1'b1, 16'd20);
    out_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    h0 = hs_cnt;
    PC = 8'hFF; dbg_r0 = 8'hEE; dbg_r3 = 8'h99;
    k = 0;
    while (busy && k < 200) begin
      out_ready = pat[k % 4];
      tick();
      k++;
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_timeout: got busy=%b want 0", busy); end
    n_cmp++; if (hs_cnt - h0 != 10) begin n_err++; $display("FAIL bp_handshakes: got %0d want 10", hs_cnt - h0); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_drop();
    PC = 8'h10; dbg_r0 = 8'h20; dbg_r1 = 8'h30; dbg_r2 = 8'h40; dbg_r3 = 8'h50; dbg_state = 3'd1;
    push_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 3'd1, 1'b1, 1'b1, 16'd20);
    out_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (4) tick();
    n_cmp++; if (out_data !== 8'h40) begin n_err++; $display("FAIL drop_byte4: got %h want 40", out_data); end
    PC = 8'h77;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (4) tick();
    n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL drop_at_last: got %b want 1", out_last); end
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL drop_end: got b=%b v=%b want 0 0", busy, out_valid); end
    repeat (2) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_queued: got %b want 0", busy); end
    push_frame(8'h77, 8'h20, 8'h30, 8'h40, 8'h50, 3'd1, 1'b1, 1'b1, 16'd20);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL drop_restart: got %b want 1", busy); end
    wait_idle("drop");
  endtask

  task automatic test_reset_mid();
    PC = 8'h42; dbg_r0 = 8'h01; dbg_r1 = 8'h02; dbg_r2 = 8'h03; dbg_r3 = 8'h04; dbg_state = 3'd6;
    push_frame(8'h42, 8'h01, 8'h02, 8'h03, 8'h04, 3'd6, 1'b1, 1'b1, 16'd20);
    out_ready = 1'b1;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    repeat (5) tick();
    n_cmp++; if (out_data !== 8'h04) begin n_err++; $display("FAIL rstmid_byte5: got %h want 04", out_data); end
    rst = 1'b1; halt = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin n_err++; $display("FAIL rstmid_abort: got v=%b b=%b l=%b want 0 0 0", out_valid, busy, out_last); end
    n_cmp++; if (cyc_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d want 0", cyc_cnt); end
    push_frame(8'h42, 8'h01, 8'h02, 8'h03, 8'h04, 3'd6, 1'b0, 1'b0, 16'd0);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_err++; $display("FAIL rstmid_restart: got v=%b d=%h want 1 a5", out_valid, out_data); end
    wait_idle("rstmid");
  endtask

  task automatic test_saturation();
    logic [7:0] got [10];
    logic [7:0] chk;
    int n;
    int g;
    rst_b = 1'b0; en_b = 1'b1; halt_b = 1'b0;
    repeat (600) tick();
    n_cmp++; if (cyc_cnt_b !== 9'd511) begin n_err++; $display("FAIL sat_cnt: got %0d want 511", cyc_cnt_b); end
    repeat (5) tick();
    n_cmp++; if (cyc_cnt_b !== 9'd511) begin n_err++; $display("FAIL sat_hold: got %0d want 511", cyc_cnt_b); end
    PC = 8'h9C; dbg_r0 = 8'h0F; dbg_r1 = 8'hF0; dbg_r2 = 8'h3C; dbg_r3 = 8'hC3; dbg_state = 3'd7;
    chk = 8'hA5 ^ 8'h9C ^ 8'h0F ^ 8'hF0 ^ 8'h3C ^ 8'hC3 ^ 8'h47 ^ 8'h01 ^ 8'hFF;
    ready_b = 1'b1;
    dump_req_b = 1'b1;
    tick();
    dump_req_b = 1'b0;
    n = 0; g = 0;
    for (int i = 0; i < 10; i++) got[i] = 8'h00;
    while (n < 10 && g < 40) begin
      if (out_valid_b) begin
        got[n] = out_data_b;
        n++;
      end
      tick();
      g++;
    end
    n_cmp++; if (n != 10) begin n_err++; $display("FAIL sat_frame_len: got %0d want 10", n); end
    n_cmp++; if (got[0] !== 8'hA5) begin n_err++; $display("FAIL sat_hdr: got %h want a5", got[0]); end
    n_cmp++; if (got[6] !== 8'h47) begin n_err++; $display("FAIL sat_stat: got %h want 47", got[6]); end
    n_cmp++; if (got[7] !== 8'h01) begin n_err++; $display("FAIL sat_cnt_hi: got %h want 01", got[7]); end
    n_cmp++; if (got[8] !== 8'hFF) begin n_err++; $display("FAIL sat_cnt_lo: got %h want ff", got[8]); end
    n_cmp++; if (got[9] !== chk) begin n_err++; $display("FAIL sat_chk: got %h want %h", got[9], chk); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; halt = 1'b0; dump_req = 1'b0; out_ready = 1'b1;
    PC = 8'h00; dbg_r0 = 8'h00; dbg_r1 = 8'h00; dbg_r2 = 8'h00; dbg_r3 = 8'h00; dbg_state = 3'd0;
    rst_b = 1'b1; en_b = 1'b0; halt_b = 1'b0; dump_req_b = 1'b0; ready_b = 1'b1;
    test_reset();
    test_counter();
    test_auto_dump();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
